// File: rtl/coreaxi4sram_wrctrl_if.sv
// AW/W/B handshake and SRAM write-port signals between the slave interface stage,
// the write-channel controller and the SRAM.
interface coreaxi4sram_wrctrl_if #(
  parameter int AXI4_DWIDTH  = 64,
  parameter int AXI4_AWIDTH  = 32,
  parameter int AXI4_IDWIDTH = 4,
  parameter int MEM_AWIDTH   = 9
);
  logic                      AWVALID_slvif;
  logic [AXI4_IDWIDTH-1:0]   AWID_slvif;
  logic [AXI4_AWIDTH-1:0]    AWADDR_slvif;
  logic [7:0]                AWLEN_slvif;
  logic [2:0]                AWSIZE_slvif;
  logic [1:0]                AWBURST_slvif;
  logic [AXI4_DWIDTH-1:0]    WDATA_slvif;
  logic [AXI4_DWIDTH/8-1:0]  WSTRB_slvif;
  logic                      WLAST_slvif;
  logic                      WVALID_slvif;
  logic                      BREADY_S;

  logic                      waddrchset_mc;
  logic                      awready_mc;
  logic                      wready_mc;
  logic                      bvalid_mc;
  logic [AXI4_IDWIDTH-1:0]   bid_mc;
  logic [1:0]                bresp_mc;

  logic                      mem_wen;
  logic [MEM_AWIDTH-1:0]     mem_waddr;
  logic [AXI4_DWIDTH-1:0]    mem_wdata;
  logic [AXI4_DWIDTH/8-1:0]  mem_wbe;

  modport slave (
    input  AWVALID_slvif, AWID_slvif, AWADDR_slvif, AWLEN_slvif, AWSIZE_slvif,
           AWBURST_slvif, WDATA_slvif, WSTRB_slvif, WLAST_slvif, WVALID_slvif, BREADY_S,
    output waddrchset_mc, awready_mc, wready_mc, bvalid_mc, bid_mc, bresp_mc,
           mem_wen, mem_waddr, mem_wdata, mem_wbe
  );

  modport master (
    output AWVALID_slvif, AWID_slvif, AWADDR_slvif, AWLEN_slvif, AWSIZE_slvif,
           AWBURST_slvif, WDATA_slvif, WSTRB_slvif, WLAST_slvif, WVALID_slvif, BREADY_S,
    input  waddrchset_mc, awready_mc, wready_mc, bvalid_mc, bid_mc, bresp_mc,
           mem_wen, mem_waddr, mem_wdata, mem_wbe
  );
endinterface

// File: rtl/coreaxi4sram_wrctrl.sv
// Write-channel controller for the AXI4 SRAM slave: runs one FIXED/INCR/WRAP burst
// at a time, issuing per-beat SRAM word writes and the B response.
module coreaxi4sram_wrctrl #(
  parameter int AXI4_DWIDTH  = 64,
  parameter int AXI4_AWIDTH  = 32,
  parameter int AXI4_IDWIDTH = 4,
  parameter int MEM_DEPTH    = 512,
  parameter int MEM_AWIDTH   = 9
) (
  input logic                  ACLK,
  input logic                  ARESETN,
  coreaxi4sram_wrctrl_if.slave bus
);
  localparam int               BS        = $clog2(AXI4_DWIDTH / 8);
  localparam logic [63:0]      MEM_BYTES = 64'(MEM_DEPTH) * 64'(AXI4_DWIDTH / 8);
  localparam logic [AXI4_AWIDTH-1:0] ONE = AXI4_AWIDTH'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state;
  logic                    awready_q, wready_q, bvalid_q, waddrchset_q, entry_q, err_q;
  logic [AXI4_IDWIDTH-1:0] id_q, bid_q;
  logic [1:0]              bresp_q, burst_q;
  logic [AXI4_AWIDTH-1:0]  addr_q;
  logic [7:0]              len_q, cnt_q;
  logic [2:0]              size_q;

  logic [AXI4_AWIDTH-1:0]  cur_addr, next_addr, blen, wlen, a_al;
  logic [7:0]              cur_len, cur_cnt;
  logic [2:0]              cur_size;
  logic [1:0]              cur_burst;
  logic [AXI4_IDWIDTH-1:0] cur_id;
  logic                    beat, last, in_range, cfg_err, beat_err, err_acc;

  // The working registers load during the first DATA cycle, so that cycle reads the
  // upstream AW fields directly; this is what allows beat 0 to land in it.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    cur_addr  = entry_q ? bus.AWADDR_slvif  : addr_q;
    cur_len   = entry_q ? bus.AWLEN_slvif   : len_q;
    cur_size  = entry_q ? bus.AWSIZE_slvif  : size_q;
    cur_burst = entry_q ? bus.AWBURST_slvif : burst_q;
    cur_id    = entry_q ? bus.AWID_slvif    : id_q;
    cur_cnt   = entry_q ? 8'd0              : cnt_q;

    blen = ONE << cur_size;
    a_al = cur_addr & ~(blen - ONE);
    wlen = (AXI4_AWIDTH'(cur_len) + ONE) * blen;
    case (cur_burst)
      2'b00:   next_addr = cur_addr;
      2'b10:   next_addr = (a_al & ~(wlen - ONE)) | ((a_al + blen) & (wlen - ONE));
      default: next_addr = a_al + blen;
    endcase

    beat     = wready_q & bus.WVALID_slvif;
    last     = (cur_cnt == cur_len);
    in_range = 64'(cur_addr) < MEM_BYTES;
    cfg_err  = (cur_burst == 2'b11)
             | ((cur_burst == 2'b10) & !(cur_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
             | (cur_size > 3'(BS));
    beat_err = beat & ((bus.WLAST_slvif != last) | !in_range);
    err_acc  = (entry_q ? 1'b0 : err_q) | cfg_err | beat_err;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      waddrchset_q <= 1'b0;
      entry_q      <= 1'b0;
      err_q        <= 1'b0;
      id_q         <= '0;
      bid_q        <= '0;
      bresp_q      <= 2'b00;
      burst_q      <= 2'b00;
      addr_q       <= '0;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      size_q       <= 3'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees
      // the pre-edge values of the others, independent of statement order.
      case (state)
        IDLE: if (bus.AWVALID_slvif) begin
          state        <= ADDR;
          awready_q    <= 1'b1;
          waddrchset_q <= 1'b1;
        end
        ADDR: begin
          state        <= DATA;
          awready_q    <= 1'b0;
          waddrchset_q <= 1'b0;
          wready_q     <= 1'b1;
          entry_q      <= 1'b1;
        end
        DATA: begin
          entry_q <= 1'b0;
          addr_q  <= beat ? next_addr : cur_addr;
          len_q   <= cur_len;
          size_q  <= cur_size;
          burst_q <= cur_burst;
          id_q    <= cur_id;
          cnt_q   <= beat ? cur_cnt + 8'd1 : cur_cnt;
          err_q   <= err_acc;
          if (beat && last) begin
            state    <= RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= cur_id;
            bresp_q  <= err_acc ? 2'b10 : 2'b00;
          end
        end
        RESP: if (bus.BREADY_S) begin
          state    <= IDLE;
          bvalid_q <= 1'b0;
          bid_q    <= '0;
          bresp_q  <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.waddrchset_mc = waddrchset_q;
  assign bus.awready_mc    = awready_q;
  assign bus.wready_mc     = wready_q;
  assign bus.bvalid_mc     = bvalid_q;
  assign bus.bid_mc        = bid_q;
  assign bus.bresp_mc      = bresp_q;

  assign bus.mem_wen   = beat & in_range;
  assign bus.mem_waddr = beat ? cur_addr[MEM_AWIDTH+BS-1:BS] : '0;
  assign bus.mem_wdata = beat ? bus.WDATA_slvif : '0;
  assign bus.mem_wbe   = beat ? bus.WSTRB_slvif : '0;
endmodule

// File: tb/tb_coreaxi4sram_wrctrl.sv
// Bench for the write-channel controller: directed bursts from the test plan plus
// randomized bursts, checked against an AXI burst-address reference model.
module tb_coreaxi4sram_wrctrl;
  localparam int DW = 64, AW = 32, IW = 4, MD = 512, MA = 9, BS = 3;
  localparam longint unsigned MEM_BYTES = 64'(MD) * 64'(DW / 8);

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  coreaxi4sram_wrctrl_if #(.AXI4_DWIDTH(DW), .AXI4_AWIDTH(AW), .AXI4_IDWIDTH(IW),
                           .MEM_AWIDTH(MA)) bus ();

  coreaxi4sram_wrctrl #(.AXI4_DWIDTH(DW), .AXI4_AWIDTH(AW), .AXI4_IDWIDTH(IW),
                        .MEM_DEPTH(MD), .MEM_AWIDTH(MA)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte address of beat i, straight from the AXI burst rules.
  function automatic longint unsigned beat_addr(input longint unsigned start, input int len,
                                                input int size, input int burst, input int i);
    longint unsigned b, al, w, lo;
    b  = 64'd1 << size;
    al = start - (start % b);
    if (i == 0 || burst == 0) return start;
    if (burst == 2) begin
      w  = 64'(len + 1) * b;
      lo = start - (start % w);
      return lo + ((al - lo + 64'(i) * b) % w);
    end
    return al + 64'(i) * b;
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "_awready"}, 64'(bus.awready_mc), 64'd0);
    check({tag, "_wready"},  64'(bus.wready_mc),  64'd0);
    check({tag, "_bvalid"},  64'(bus.bvalid_mc),  64'd0);
    check({tag, "_bid"},     64'(bus.bid_mc),     64'd0);
    check({tag, "_bresp"},   64'(bus.bresp_mc),   64'd0);
    check({tag, "_awset"},   64'(bus.waddrchset_mc), 64'd0);
    check({tag, "_wen"},     64'(bus.mem_wen),    64'd0);
    check({tag, "_wdata"},   64'(bus.mem_wdata),  64'd0);
  endtask

  // Called at a negedge; returns at the negedge following the B handshake.
  task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [3:0] id, input int wlast_at,
                           input bit gaps, input int bdelay, input bit hold_aw);
    longint unsigned a;
    logic       exp_err;
    logic [1:0] exp_resp;
    logic [63:0] wd;
    logic [7:0]  ws;
    int k, cyc;
    exp_err = (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || (wlast_at != len);

    bus.AWVALID_slvif = 1'b1;
    bus.AWID_slvif    = id;
    bus.AWADDR_slvif  = addr;
    bus.AWLEN_slvif   = 8'(len);
    bus.AWSIZE_slvif  = 3'(size);
    bus.AWBURST_slvif = 2'(burst);
    @(posedge ACLK); @(negedge ACLK);
    check("awready", 64'(bus.awready_mc), 64'd1);
    check("awset", 64'(bus.waddrchset_mc), 64'd1);
    check("wready_in_addr", 64'(bus.wready_mc), 64'd0);
    @(posedge ACLK); @(negedge ACLK);
    bus.AWVALID_slvif = 1'b0;
    check("awready_drop", 64'(bus.awready_mc), 64'd0);

    k = 0;
    cyc = 0;
    while (k <= len) begin
      bus.WVALID_slvif = (!gaps || cyc > 3 * (len + 1)) ? 1'b1 : 1'($urandom_range(3) != 0);
      wd = {$urandom, $urandom};
      ws = 8'($urandom);
      bus.WDATA_slvif = wd;
      bus.WSTRB_slvif = ws;
      bus.WLAST_slvif = (k == wlast_at);
      #1;
      check("wready", 64'(bus.wready_mc), 64'd1);
      check("bvalid_in_data", 64'(bus.bvalid_mc), 64'd0);
      if (bus.WVALID_slvif) begin
        a = beat_addr(64'(addr), len, size, burst, k);
        if (a >= MEM_BYTES) begin
          exp_err = 1'b1;
          check("wen_oor", 64'(bus.mem_wen), 64'd0);
        end else begin
          check("wen", 64'(bus.mem_wen), 64'd1);
          check("waddr", 64'(bus.mem_waddr), (a >> BS) % 64'(MD));
          check("wdata", bus.mem_wdata, wd);
          check("wbe", 64'(bus.mem_wbe), 64'(ws));
        end
        k++;
      end else begin
        check("wen_gap", 64'(bus.mem_wen), 64'd0);
      end
      cyc++;
      @(posedge ACLK); @(negedge ACLK);
    end

    exp_resp = exp_err ? 2'b10 : 2'b00;
    bus.WVALID_slvif = 1'b0;
    bus.WLAST_slvif  = 1'b0;
    if (hold_aw) begin
      bus.AWVALID_slvif = 1'b1;
      bus.AWID_slvif    = ~id;
      bus.AWADDR_slvif  = 32'h0;
    end
    for (int d = 0; d <= bdelay; d++) begin
      bus.BREADY_S = (d == bdelay);
      #1;
      check("bvalid", 64'(bus.bvalid_mc), 64'd1);
      check("bid", 64'(bus.bid_mc), 64'(id));
      check("bresp", 64'(bus.bresp_mc), 64'(exp_resp));
      check("wready_in_resp", 64'(bus.wready_mc), 64'd0);
      check("awready_in_resp", 64'(bus.awready_mc), 64'd0);
      @(posedge ACLK); @(negedge ACLK);
    end
    bus.BREADY_S = 1'b0;
    check("bvalid_drop", 64'(bus.bvalid_mc), 64'd0);
    check("awready_after_b", 64'(bus.awready_mc), 64'd0);
  endtask

  initial begin
    int len, size, burst, wl;
    bus.AWVALID_slvif = 1'b0;
    bus.AWID_slvif    = '0;
    bus.AWADDR_slvif  = '0;
    bus.AWLEN_slvif   = '0;
    bus.AWSIZE_slvif  = '0;
    bus.AWBURST_slvif = '0;
    bus.WDATA_slvif   = '0;
    bus.WSTRB_slvif   = '0;
    bus.WLAST_slvif   = 1'b0;
    bus.WVALID_slvif  = 1'b0;
    bus.BREADY_S      = 1'b0;

    repeat (3) @(negedge ACLK);
    idle_outputs("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);

    run_burst(32'h10, 3, 3, 1, 4'h5, 3, 1'b0, 0, 1'b0);          // INCR
    run_burst(32'h18, 3, 3, 2, 4'h6, 3, 1'b0, 0, 1'b0);          // WRAP
    run_burst(32'h40, 2, 3, 0, 4'h7, 2, 1'b0, 0, 1'b0);          // FIXED
    run_burst(32'h80, 3, 3, 1, 4'h8, 1, 1'b0, 0, 1'b0);          // early WLAST
    run_burst(32'(MD * 8 - 8), 1, 3, 1, 4'h9, 1, 1'b0, 0, 1'b0); // out of range
    run_burst(32'h20, 0, 3, 2, 4'hA, 0, 1'b0, 0, 1'b0);          // WRAP, illegal len
    run_burst(32'h30, 1, 3, 3, 4'hB, 1, 1'b0, 0, 1'b0);          // reserved burst
    run_burst(32'h100, 2, 3, 1, 4'hC, 2, 1'b1, 5, 1'b1);         // B back-pressure
    run_burst(32'h200, 1, 2, 1, 4'hD, 1, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      size  = int'($urandom_range(3));
      burst = int'($urandom_range(3));
      case ($urandom_range(3))
        0:       len = 1;
        1:       len = 3;
        2:       len = 7;
        default: len = 15;
      endcase
      if (burst != 2) len = int'($urandom_range(15));
      wl = ($urandom_range(7) == 0) ? int'($urandom_range(len + 1)) : len;
      run_burst(32'($urandom_range(int'(MEM_BYTES) + 64)), len, size, burst, 4'($urandom),
                wl, 1'b1, int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    // Reset in the middle of a burst.
    bus.AWVALID_slvif = 1'b1;
    bus.AWID_slvif    = 4'h3;
    bus.AWADDR_slvif  = 32'h100;
    bus.AWLEN_slvif   = 8'd7;
    bus.AWSIZE_slvif  = 3'd3;
    bus.AWBURST_slvif = 2'b01;
    @(posedge ACLK); @(negedge ACLK);
    @(posedge ACLK); @(negedge ACLK);
    bus.AWVALID_slvif = 1'b0;
    bus.WVALID_slvif  = 1'b1;
    bus.WDATA_slvif   = 64'h1234;
    bus.WLAST_slvif   = 1'b0;
    repeat (2) begin @(posedge ACLK); @(negedge ACLK); end
    ARESETN = 1'b0;
    #1;
    idle_outputs("midreset");
    @(posedge ACLK); @(negedge ACLK);
    ARESETN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("post_reset_wen", 64'(bus.mem_wen), 64'd0);
      check("post_reset_bvalid", 64'(bus.bvalid_mc), 64'd0);
      check("post_reset_wready", 64'(bus.wready_mc), 64'd0);
      @(posedge ACLK); @(negedge ACLK);
    end
    bus.WVALID_slvif = 1'b0;
    run_burst(32'h48, 1, 3, 1, 4'h4, 1, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
